// File: rtl/stream_mux_4x1_if.sv
// Handshake bundle for the 4-to-1 stream multiplexer: four input channels in, one tagged channel out.
interface stream_mux_4x1_if #(
    parameter int unsigned WIDTH = 8
);
    logic [3:0]         in_valid;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         in_last;
    logic [3:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_sel;
    logic               out_last;
    logic               out_ready;

    // Multiplexer side.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_last
    );

    // Source/sink side (producers of input channels, consumer of output).
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_last
    );
endinterface

// File: rtl/stream_mux_4x1.sv
// Four-to-one stream multiplexer: round-robin arbitration, packet locking, registered tagged output.
module stream_mux_4x1 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    stream_mux_4x1_if.slave  bus
);
    localparam int unsigned NCH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       lock_q, lock_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]       out_sel_q, out_sel_d;
    logic             out_last_q, out_last_d;

    logic [1:0]       grant;
    logic             grant_en;
    logic             slot_free;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;

    // Arbitration: locked channel while in a packet, otherwise first valid from ptr upward.
    always_comb begin
        grant    = ptr_q;
        grant_en = 1'b0;
        if (state_q == LOCK) begin
            grant    = lock_q;
            grant_en = bus.in_valid[lock_q];
        end else begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (bus.in_valid[2'(ptr_q + 2'(i))]) begin
                    grant = 2'(ptr_q + 2'(i));
                end
            end
            grant_en = |bus.in_valid;
        end
    end

    // Granted-channel payload selection.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (grant == 2'(k)) begin
                sel_data = bus.in_data[k*WIDTH +: WIDTH];
                sel_last = bus.in_last[k];
            end
        end
    end

    // Output slot is free when empty or draining this cycle; reset gates acceptance.
    assign slot_free    = !out_valid_q || bus.out_ready;
    assign accept       = grant_en && slot_free && rst_n;
    assign bus.in_ready = accept ? 4'(4'b0001 << grant) : 4'b0000;

    // Next-state logic for arbitration FSM and output slot.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lock_d      = lock_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_last_d  = out_last_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sel_last) begin
                        ptr_d = 2'(grant + 2'd1);
                    end else begin
                        state_d = LOCK;
                        lock_d  = grant;
                    end
                end
            end
            LOCK: begin
                if (accept && sel_last) begin
                    state_d = IDLE;
                    ptr_d   = 2'(lock_q + 2'd1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_sel_d   = grant;
            out_last_d  = sel_last;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            lock_q      <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_stream_mux_4x1.sv
// Directed bench for stream_mux_4x1: reset, round robin, packet lock, backpressure, sparse traffic, mid-packet reset.
module tb_stream_mux_4x1;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    stream_mux_4x1_if #(.WIDTH(WIDTH)) sif ();

    stream_mux_4x1 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [WIDTH-1:0] d, input logic l);
        sif.in_data[k*WIDTH +: WIDTH] = d;
        sif.in_last[k] = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                             input logic [1:0] s, input logic l);
        check_eq({tag, ".valid"}, 32'(sif.out_valid), 32'(v));
        check_eq({tag, ".data"},  32'(sif.out_data),  32'(d));
        check_eq({tag, ".sel"},   32'(sif.out_sel),   32'(s));
        check_eq({tag, ".last"},  32'(sif.out_last),  32'(l));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        sif.in_valid  = 4'b1111;
        sif.in_last   = 4'b1111;
        sif.in_data   = '0;
        sif.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) set_ch(k, 8'(8'hA0 + k), 1'b1);

        // Reset: outputs and in_ready held low while rst_n=0.
        #3;
        check_out("rst", 1'b0, 8'h00, 2'd0, 1'b0);
        check_eq("rst.in_ready", 32'(sif.in_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst.first_grant", 32'(sif.in_ready), 32'b0001);

        // Round robin across four single-beat channels.
        for (int k = 0; k < 5; k++) begin
            tick();
            check_out($sformatf("rr%0d", k), 1'b1, 8'(8'hA0 + (k % 4)), 2'(k % 4), 1'b1);
            check_eq($sformatf("rr%0d.in_ready", k), 32'(sif.in_ready), 32'(1 << ((k + 1) % 4)));
        end
        sif.in_valid = 4'b0000;
        tick();
        check_out("drain", 1'b0, 8'hA0, 2'd0, 1'b1);

        // Sparse: ptr=1, lone channel 0 still granted immediately.
        sif.in_valid = 4'b0001;
        set_ch(0, 8'h3C, 1'b1);
        #1;
        check_eq("sparse.in_ready", 32'(sif.in_ready), 32'b0001);
        tick();
        check_out("sparse", 1'b1, 8'h3C, 2'd0, 1'b1);
        sif.in_valid = 4'b1111;
        #1;
        check_eq("sparse.ptr1", 32'(sif.in_ready), 32'b0010);
        sif.in_valid = 4'b0000;
        tick();
        check_eq("sparse.drain", 32'(sif.out_valid), 32'h0);

        // Packet lock: channel 2 three-beat packet while channel 0 waits.
        sif.in_valid = 4'b0101;
        set_ch(0, 8'h77, 1'b1);
        set_ch(2, 8'h11, 1'b0);
        #1;
        check_eq("lock.grant", 32'(sif.in_ready), 32'b0100);
        tick();
        check_out("lock.b0", 1'b1, 8'h11, 2'd2, 1'b0);
        set_ch(2, 8'h22, 1'b0);
        #1;
        check_eq("lock.hold1", 32'(sif.in_ready), 32'b0100);
        tick();
        check_out("lock.b1", 1'b1, 8'h22, 2'd2, 1'b0);
        set_ch(2, 8'h33, 1'b1);
        #1;
        check_eq("lock.hold2", 32'(sif.in_ready), 32'b0100);
        tick();
        check_out("lock.b2", 1'b1, 8'h33, 2'd2, 1'b1);
        check_eq("lock.next", 32'(sif.in_ready), 32'b0001);
        tick();
        check_out("lock.ch0", 1'b1, 8'h77, 2'd0, 1'b1);

        // Backpressure: 5A held stable for five stalled cycles.
        sif.in_valid = 4'b0010;
        set_ch(1, 8'h5A, 1'b1);
        tick();
        check_out("bp.load", 1'b1, 8'h5A, 2'd1, 1'b1);
        sif.out_ready = 1'b0;
        set_ch(1, 8'h5B, 1'b1);
        for (int c = 0; c < 5; c++) begin
            #1;
            check_eq($sformatf("bp%0d.in_ready", c), 32'(sif.in_ready), 32'h0);
            tick();
            check_out($sformatf("bp%0d", c), 1'b1, 8'h5A, 2'd1, 1'b1);
        end
        sif.out_ready = 1'b1;
        #1;
        check_eq("bp.release", 32'(sif.in_ready), 32'b0010);
        tick();
        check_out("bp.next", 1'b1, 8'h5B, 2'd1, 1'b1);
        sif.in_valid = 4'b0000;
        tick();
        check_eq("bp.drain", 32'(sif.out_valid), 32'h0);

        // Reset mid-packet on channel 3; afterwards FSM must be IDLE with ptr=0.
        sif.in_valid = 4'b1000;
        set_ch(3, 8'hC1, 1'b0);
        tick();
        check_out("mid.b0", 1'b1, 8'hC1, 2'd3, 1'b0);
        set_ch(3, 8'hC2, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid.rst_valid", 32'(sif.out_valid), 32'h0);
        check_eq("mid.rst_ready", 32'(sif.in_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sif.in_valid = 4'b0010;
        set_ch(1, 8'hD1, 1'b1);
        #1;
        check_eq("mid.idle_grant", 32'(sif.in_ready), 32'b0010);
        tick();
        check_out("mid.ch1", 1'b1, 8'hD1, 2'd1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
